fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 89 ++++++++
 tb/tb_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage.
// Holds the fetch PC, drives the word address of a 1-cycle-latency ROM, and
// presents each fetched instruction with its PC to decode. A BOOT cycle after
// reset re-presents RESET_PC, because the ROM's own address register comes out
// of reset at 0. Redirects restart fetch at a new target, and a stall holds the
// current instruction in place.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [29:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_f;
    logic [31:0] pc_next_s;
    logic [31:0] count_r;

    // Next-state and next-PC selection: reset, then redirect, then hold, then advance.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_f + 32'd4;
        if (rst) begin
            state_next_s = ST_RESET;
            pc_next_s    = RESET_PC;
        end else begin
            case (state_r)
                ST_RESET: state_next_s = ST_BOOT;
                ST_BOOT:  state_next_s = ST_RUN;
                ST_RUN:   state_next_s = ST_RUN;
                default:  state_next_s = ST_RESET;
            endcase
            if (redirect) begin
                pc_next_s = {redirect_pc[31:2], 2'b00};
            end else if (stall || (state_r != ST_RUN)) begin
                // RESET and BOOT keep RESET_PC on the ROM address so its data
                // lines up with pc_f once RUN begins.
                pc_next_s = pc_f;
            end else begin
                pc_next_s = pc_f + 32'd4;
            end
        end
    end

    // State and PC registers; the PC takes the selected next value every edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_RESET;
            pc_f    <= RESET_PC;
        end else begin
            state_r <= state_next_s;
            pc_f    <= pc_next_s;
        end
    end

    // Delivered-instruction counter: counts cycles where decode takes a live instruction.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= 32'd0;
        end else if (if_valid && !stall) begin
            count_r <= count_r + 32'd1;
        end else begin
            count_r <= count_r;
        end
    end

    assign imem_addr   = pc_next_s[31:2];
    assign if_pc       = pc_f;
    assign if_inst     = imem_inst;
    assign if_valid    = (state_r == ST_RUN) && !redirect;
    assign fetch_count = count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed stimulus with a scoreboard of delivered instructions.
// Each ROM word n holds the value n. A second instance with RESET_PC=0x40
// exercises the non-zero boot address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic [29:0] imem_addr;
    logic [31:0] imem_inst;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_valid;
    logic [31:0] fetch_count;

    logic        stall2 = 1'b0;
    logic        redirect2 = 1'b0;
    logic [31:0] redirect_pc2 = 32'd0;
    logic [29:0] imem_addr2;
    logic [31:0] imem_inst2;
    logic [31:0] if_inst2;
    logic [31:0] if_pc2;
    logic        if_valid2;
    logic [31:0] fetch_count2;

    logic [29:0] rom_q;
    logic [29:0] rom_q2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] cnt;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_inst(imem_inst),
        .if_inst(if_inst), .if_pc(if_pc), .if_valid(if_valid),
        .fetch_count(fetch_count)
    );

    fetch_unit #(.RESET_PC(32'h00000040)) dut2 (
        .clk(clk), .rst(rst), .stall(stall2), .redirect(redirect2),
        .redirect_pc(redirect_pc2), .imem_addr(imem_addr2), .imem_inst(imem_inst2),
        .if_inst(if_inst2), .if_pc(if_pc2), .if_valid(if_valid2),
        .fetch_count(fetch_count2)
    );

    // ROM models: address register cleared by reset, word n holds n.
    always @(posedge clk) begin
        if (rst) begin
            rom_q  <= 30'd0;
            rom_q2 <= 30'd0;
        end else begin
            rom_q  <= imem_addr;
            rom_q2 <= imem_addr2;
        end
    end
    assign imem_inst  = {2'b00, rom_q};
    assign imem_inst2 = {2'b00, rom_q2};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic expect_fetch(input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] cnt);
        exp_t e;
        e.pc = pc;
        e.inst = inst;
        e.cnt = cnt;
        exp_q.push_back(e);
    endtask

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic step(input logic r, input logic s, input logic d, input logic [31:0] t);
        @(posedge clk);
        #1;
        rst = r;
        stall = s;
        redirect = d;
        redirect_pc = t;
        @(negedge clk);
    endtask

    // Monitor: every delivered instruction must match the head of the scoreboard.
    always @(negedge clk) begin
        if (if_valid === 1'b1 && stall === 1'b0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_fetch: got pc %h inst %h with empty queue", if_pc, if_inst);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("deliver_pc", if_pc, e.pc);
                check("deliver_inst", if_inst, e.inst);
                check("deliver_count", fetch_count, e.cnt);
            end
        end
    end

    initial begin
        // Reset held for a few cycles.
        step(1'b1, 1'b0, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_pc", if_pc, 32'd0);
        check("rst_count", fetch_count, 32'd0);
        check("rst_imem_addr", {2'b00, imem_addr}, 32'd0);
        check("rst2_imem_addr", {2'b00, imem_addr2}, 32'h10);

        // Release: two invalid cycles (reset-exit, BOOT), then fetch from RESET_PC.
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("rel_valid", {31'd0, if_valid}, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("boot_valid", {31'd0, if_valid}, 32'd0);
        check("boot2_valid", {31'd0, if_valid2}, 32'd0);
        expect_fetch(32'h0, 32'h0, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("boot2_first_valid", {31'd0, if_valid2}, 32'd1);
        check("boot2_first_pc", if_pc2, 32'h40);
        check("boot2_first_inst", if_inst2, 32'h10);
        expect_fetch(32'h4, 32'h1, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        check("boot2_second_pc", if_pc2, 32'h44);
        check("boot2_second_inst", if_inst2, 32'h11);

        // Redirect to 0x103 at pc 0x8: killed this cycle, 0x100 next.
        step(1'b0, 1'b0, 1'b1, 32'h103);
        check("redir_pc_shown", if_pc, 32'h8);
        check("redir_valid", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h100, 32'h40, 32'd2);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect to 0x10, then stall three cycles there.
        step(1'b0, 1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'd0);
            check("stall_valid", {31'd0, if_valid}, 32'd1);
            check("stall_pc", if_pc, 32'h10);
            check("stall_inst", if_inst, 32'h4);
            check("stall_count", fetch_count, 32'd3);
            check("stall_imem_addr", {2'b00, imem_addr}, 32'h4);
        end
        expect_fetch(32'h10, 32'h4, 32'd3);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        expect_fetch(32'h14, 32'h5, 32'd4);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Redirect and stall together: redirect wins.
        step(1'b0, 1'b1, 1'b1, 32'h20);
        check("redir_stall_valid", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h20, 32'h8, 32'd5);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Back-to-back redirects: the last target takes effect.
        step(1'b0, 1'b0, 1'b1, 32'h200);
        step(1'b0, 1'b0, 1'b1, 32'h300);
        check("redir2_pc", if_pc, 32'h200);
        check("redir2_valid", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h300, 32'hC0, 32'd6);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // PC wrap from the top of the address space.
        step(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        expect_fetch(32'hFFFFFFFC, 32'h3FFFFFFF, 32'd7);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        expect_fetch(32'h0, 32'h0, 32'd8);
        step(1'b0, 1'b0, 1'b0, 32'd0);

        // Reset mid-run with redirect high: reset wins.
        step(1'b1, 1'b0, 1'b1, 32'h500);
        check("midrst_imem_addr", {2'b00, imem_addr}, 32'd0);
        check("midrst_valid", {31'd0, if_valid}, 32'd0);
        step(1'b1, 1'b0, 1'b1, 32'h500);
        check("midrst_after_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_after_pc", if_pc, 32'd0);
        check("midrst_after_count", fetch_count, 32'd0);

        // Release, then redirect during BOOT.
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b0, 1'b1, 32'h80);
        check("bootredir_valid", {31'd0, if_valid}, 32'd0);
        expect_fetch(32'h80, 32'h20, 32'd0);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        expect_fetch(32'h84, 32'h21, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 1'b0, 32'd0);

        check("scoreboard_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
